// File: rtl/term_writer.sv
// rtl/term_writer.sv - character stream to text RAM writer with cursor tracking and scroll-offset rotation
// Accepts bytes over valid/ready, interprets CR/LF/BS/TAB/FF and issues registered text RAM writes.
module term_writer #(
  parameter int          COLS   = 80,
  parameter int          ROWS   = 25,
  parameter int          TAB_W  = 8,
  parameter logic [7:0]  FILL   = 8'h20,
  parameter int          ADDR_W = $clog2(COLS*ROWS)
) (
  input  logic                     clk100,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [7:0]               wr_data,
  output logic [$clog2(ROWS)-1:0]  scroll_row,
  output logic [$clog2(ROWS)-1:0]  cursor_row,
  output logic [$clog2(COLS)-1:0]  cursor_col
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [RW-1:0]     LAST_ROW = RW'(ROWS-1);
  localparam logic [CW-1:0]     LAST_COL = CW'(COLS-1);

  typedef enum logic [1:0] {IDLE, CLEAR_LINE, CLEAR_ALL} state_t;

  state_t              state, state_nxt;
  logic                wr_en_nxt;
  logic [ADDR_W-1:0]   wr_addr_nxt;
  logic [7:0]          wr_data_nxt;
  logic [RW-1:0]       scroll_nxt, crow_nxt;
  logic [CW-1:0]       ccol_nxt;
  // clr_ptr is the next address to clear, clr_left the writes still owed
  logic [ADDR_W-1:0]   clr_ptr, clr_ptr_nxt;
  logic [ADDR_W-1:0]   clr_left, clr_left_nxt;
  logic                do_nl;

  logic                accept;
  logic [RW:0]         row_sum;
  logic [RW-1:0]       prow;
  logic [ADDR_W-1:0]   char_addr, line_base;
  logic [CW:0]         tab_next;

  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign row_sum   = {1'b0, scroll_row} + {1'b0, cursor_row};
  assign prow      = (row_sum >= (RW+1)'(ROWS)) ? RW'(row_sum - (RW+1)'(ROWS)) : RW'(row_sum);
  assign char_addr = ADDR_W'(prow) * COLS_A + ADDR_W'(cursor_col);
  assign line_base = ADDR_W'(scroll_row) * COLS_A;
  assign tab_next  = ({1'b0, cursor_col} | (CW+1)'(TAB_W-1)) + (CW+1)'(1);

  always_comb begin
    state_nxt    = state;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    scroll_nxt   = scroll_row;
    crow_nxt     = cursor_row;
    ccol_nxt     = cursor_col;
    clr_ptr_nxt  = clr_ptr;
    clr_left_nxt = clr_left;
    do_nl        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = char_addr;
            wr_data_nxt = in_data;
            if (cursor_col == LAST_COL) begin
              ccol_nxt = '0;
              do_nl    = 1'b1;
            end else begin
              ccol_nxt = cursor_col + CW'(1);
            end
          end else begin
            case (in_data)
              8'h0A: do_nl = 1'b1;
              8'h0D: ccol_nxt = '0;
              8'h08: if (cursor_col != '0) ccol_nxt = cursor_col - CW'(1);
              8'h09: ccol_nxt = (tab_next > {1'b0, LAST_COL}) ? LAST_COL : CW'(tab_next);
              8'h0C: begin
                crow_nxt     = '0;
                ccol_nxt     = '0;
                scroll_nxt   = '0;
                state_nxt    = CLEAR_ALL;
                wr_en_nxt    = 1'b1;
                wr_addr_nxt  = '0;
                wr_data_nxt  = FILL;
                clr_ptr_nxt  = ADDR_W'(1);
                clr_left_nxt = ADDR_W'(ROWS*COLS-1);
              end
              default: ;
            endcase
          end
          if (do_nl) begin
            if (cursor_row != LAST_ROW) begin
              crow_nxt = cursor_row + RW'(1);
            end else begin
              scroll_nxt = (scroll_row == LAST_ROW) ? '0 : scroll_row + RW'(1);
              state_nxt  = CLEAR_LINE;
              // A wrapping printable keeps its own write first; the clear follows it.
              if (wr_en_nxt) begin
                clr_ptr_nxt  = line_base;
                clr_left_nxt = COLS_A;
              end else begin
                wr_en_nxt    = 1'b1;
                wr_addr_nxt  = line_base;
                wr_data_nxt  = FILL;
                clr_ptr_nxt  = line_base + ADDR_W'(1);
                clr_left_nxt = COLS_A - ADDR_W'(1);
              end
            end
          end
        end
      end
      CLEAR_LINE, CLEAR_ALL: begin
        if (clr_left == '0) begin
          state_nxt = IDLE;
        end else begin
          wr_en_nxt    = 1'b1;
          wr_addr_nxt  = clr_ptr;
          wr_data_nxt  = FILL;
          clr_ptr_nxt  = clr_ptr + ADDR_W'(1);
          clr_left_nxt = clr_left - ADDR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      scroll_row <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      clr_ptr    <= '0;
      clr_left   <= '0;
    end else begin
      state      <= state_nxt;
      wr_en      <= wr_en_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_data    <= wr_data_nxt;
      scroll_row <= scroll_nxt;
      cursor_row <= crow_nxt;
      cursor_col <= ccol_nxt;
      clr_ptr    <= clr_ptr_nxt;
      clr_left   <= clr_left_nxt;
    end
  end

endmodule

// File: tb/tb_term_writer.sv
// tb/tb_term_writer.sv - directed self-checking bench for term_writer
module tb_term_writer;

  logic        clk100 = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic [4:0]  scroll_row;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;

  int errors = 0;
  int checks = 0;
  int wcount = 0;

  term_writer dut (
    .clk100(clk100), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .scroll_row(scroll_row), .cursor_row(cursor_row), .cursor_col(cursor_col)
  );

  always #5 clk100 = ~clk100;

  always @(negedge clk100) if (wr_en === 1'b1) wcount++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Returns at 1 time unit after the accepting edge.
  task automatic send(input logic [7:0] b);
    int t = 0;
    @(negedge clk100);
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 5000) begin
      @(negedge clk100);
      t++;
    end
    if (in_ready !== 1'b1) begin
      errors++; checks++;
      $display("FAIL send_timeout: byte %h not accepted, in_ready=%b required 1", b, in_ready);
    end
    @(posedge clk100);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk100);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk100);
    @(negedge clk100);
    rst = 1'b0;
    wcount = 0;
  endtask

  // Starts at the first clear cycle; returns at the last clear cycle.
  task automatic check_clear(input string name, input int base, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin @(posedge clk100); #1; end
      if (wr_en !== 1'b1 || wr_addr !== 11'(base + i) || wr_data !== 8'h20 || in_ready !== 1'b0) begin
        if (bad == 0)
          $display("FAIL %s: cycle %0d wr_en=%b addr=%0d data=%h rdy=%b required 1 %0d 20 0",
                   name, i, wr_en, wr_addr, wr_data, in_ready, base + i);
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
    @(posedge clk100); #1;
    checks++;
    if (in_ready !== 1'b1 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL %s_end: in_ready=%b wr_en=%b required 1 0", name, in_ready, wr_en);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk100);
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_data, scroll_row, cursor_row, cursor_col, in_ready} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b addr=%0d data=%h scr=%0d row=%0d col=%0d rdy=%b required all 0",
               wr_en, wr_addr, wr_data, scroll_row, cursor_row, cursor_col, in_ready);
    end
    @(negedge clk100);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    end
    wcount = 0;
  endtask

  task automatic test_printable();
    int wc;
    send(8'h41);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 11'd0 || wr_data !== 8'h41 || cursor_col !== 7'd1) begin
      errors++;
      $display("FAIL print_A: en=%b addr=%0d data=%h col=%0d required 1 0 41 1", wr_en, wr_addr, wr_data, cursor_col);
    end
    @(posedge clk100); #1;
    checks++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL print_one_cycle: wr_en=%b required 0", wr_en);
    end
    wc = wcount;
    send(8'h0D);
    send(8'h0A);
    checks++;
    if (cursor_row !== 5'd1 || cursor_col !== 7'd0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL crlf_cursor: row=%0d col=%0d en=%b required 1 0 0", cursor_row, cursor_col, wr_en);
    end
    @(negedge clk100); #1;
    checks++;
    if (wcount !== wc) begin
      errors++;
      $display("FAIL crlf_nowrite: writes=%0d required %0d", wcount, wc);
    end
  endtask

  task automatic test_line_wrap();
    do_reset();
    repeat (80) send(8'h78);
    checks++;
    if (cursor_row !== 5'd1 || cursor_col !== 7'd0) begin
      errors++;
      $display("FAIL wrap_cursor: row=%0d col=%0d required 1 0", cursor_row, cursor_col);
    end
    send(8'h42);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 11'd80 || wr_data !== 8'h42 || cursor_row !== 5'd1 || cursor_col !== 7'd1) begin
      errors++;
      $display("FAIL wrap_B: en=%b addr=%0d data=%h row=%0d col=%0d required 1 80 42 1 1",
               wr_en, wr_addr, wr_data, cursor_row, cursor_col);
    end
    @(posedge clk100); #1;
    checks++;
    if (in_ready !== 1'b1 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL wrap_noclear: in_ready=%b wr_en=%b required 1 0", in_ready, wr_en);
    end
    @(negedge clk100); #1;
    checks++;
    if (wcount !== 81) begin
      errors++;
      $display("FAIL wrap_count: writes=%0d required 81", wcount);
    end
  endtask

  task automatic test_scroll();
    do_reset();
    repeat (24) send(8'h0A);
    @(negedge clk100); #1;
    checks++;
    if (cursor_row !== 5'd24 || wcount !== 0) begin
      errors++;
      $display("FAIL lf_to_bottom: row=%0d writes=%0d required 24 0", cursor_row, wcount);
    end
    send(8'h0A);
    checks++;
    if (scroll_row !== 5'd1 || cursor_row !== 5'd24) begin
      errors++;
      $display("FAIL scroll_one: scroll=%0d row=%0d required 1 24", scroll_row, cursor_row);
    end
    check_clear("clear_row0", 0, 80);
    send(8'h43);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 11'd0 || wr_data !== 8'h43) begin
      errors++;
      $display("FAIL scroll_C: en=%b addr=%0d data=%h required 1 0 43", wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_scroll_wrap();
    send(8'h0D);
    repeat (23) send(8'h0A);
    checks++;
    if (scroll_row !== 5'd24 || cursor_row !== 5'd24) begin
      errors++;
      $display("FAIL scroll_24: scroll=%0d row=%0d required 24 24", scroll_row, cursor_row);
    end
    send(8'h0A);
    checks++;
    if (scroll_row !== 5'd0) begin
      errors++;
      $display("FAIL scroll_wrap: scroll=%0d required 0", scroll_row);
    end
    check_clear("clear_row24", 1920, 80);
    send(8'h44);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 11'd1920 || wr_data !== 8'h44) begin
      errors++;
      $display("FAIL wrap_D: en=%b addr=%0d data=%h required 1 1920 44", wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_last_cell();
    send(8'h0D);
    repeat (79) send(8'h79);
    checks++;
    if (cursor_row !== 5'd24 || cursor_col !== 7'd79) begin
      errors++;
      $display("FAIL last_cell_pos: row=%0d col=%0d required 24 79", cursor_row, cursor_col);
    end
    send(8'h7A);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 11'd1999 || wr_data !== 8'h7A || in_ready !== 1'b0 ||
        cursor_col !== 7'd0 || scroll_row !== 5'd1) begin
      errors++;
      $display("FAIL last_cell_write: en=%b addr=%0d data=%h rdy=%b col=%0d scr=%0d required 1 1999 7a 0 0 1",
               wr_en, wr_addr, wr_data, in_ready, cursor_col, scroll_row);
    end
    @(posedge clk100); #1;
    check_clear("last_cell_clear", 0, 80);
  endtask

  task automatic test_tab_bs();
    int wc;
    do_reset();
    repeat (3) send(8'h20);
    send(8'h09);
    checks++;
    if (cursor_col !== 7'd8) begin
      errors++;
      $display("FAIL tab_3: col=%0d required 8", cursor_col);
    end
    repeat (8) send(8'h09);
    repeat (6) send(8'h20);
    send(8'h09);
    checks++;
    if (cursor_col !== 7'd79) begin
      errors++;
      $display("FAIL tab_78: col=%0d required 79", cursor_col);
    end
    send(8'h09);
    checks++;
    if (cursor_col !== 7'd79 || cursor_row !== 5'd0) begin
      errors++;
      $display("FAIL tab_79: row=%0d col=%0d required 0 79", cursor_row, cursor_col);
    end
    send(8'h0D);
    send(8'h08);
    checks++;
    if (cursor_col !== 7'd0) begin
      errors++;
      $display("FAIL bs_0: col=%0d required 0", cursor_col);
    end
    repeat (5) send(8'h20);
    send(8'h08);
    checks++;
    if (cursor_col !== 7'd4) begin
      errors++;
      $display("FAIL bs_5: col=%0d required 4", cursor_col);
    end
    @(negedge clk100); #1;
    wc = wcount;
    send(8'h07);
    checks++;
    if (wr_en !== 1'b0 || in_ready !== 1'b1 || cursor_col !== 7'd4) begin
      errors++;
      $display("FAIL ignore_07: en=%b rdy=%b col=%0d required 0 1 4", wr_en, in_ready, cursor_col);
    end
    send(8'h80);
    @(negedge clk100); #1;
    checks++;
    if (wcount !== wc || cursor_col !== 7'd4) begin
      errors++;
      $display("FAIL ignore_80: writes=%0d col=%0d required %0d 4", wcount, cursor_col, wc);
    end
  endtask

  task automatic test_ff_full();
    send(8'h0A);
    send(8'h0C);
    checks++;
    if (cursor_row !== 5'd0 || cursor_col !== 7'd0 || scroll_row !== 5'd0) begin
      errors++;
      $display("FAIL ff_cursor: row=%0d col=%0d scr=%0d required 0 0 0", cursor_row, cursor_col, scroll_row);
    end
    check_clear("ff_clear", 0, 2000);
  endtask

  task automatic test_ff_reset();
    int bad = 0;
    do_reset();
    repeat (25) send(8'h0A);
    send(8'h41);
    checks++;
    if (scroll_row !== 5'd1 || wr_addr !== 11'd0 || cursor_col !== 7'd1) begin
      errors++;
      $display("FAIL ffr_setup: scr=%0d addr=%0d col=%0d required 1 0 1", scroll_row, wr_addr, cursor_col);
    end
    send(8'h0C);
    checks++;
    if (scroll_row !== 5'd0 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
      errors++;
      $display("FAIL ffr_cursor: scr=%0d row=%0d col=%0d required 0 0 0", scroll_row, cursor_row, cursor_col);
    end
    for (int i = 0; i <= 500; i++) begin
      if (i > 0) begin @(posedge clk100); #1; end
      if (wr_en !== 1'b1 || wr_addr !== 11'(i) || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ffr_sequence: %0d bad cycles required 0", bad);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_data, scroll_row, cursor_row, cursor_col, in_ready} !== 37'd0) begin
      errors++;
      $display("FAIL ffr_async_reset: en=%b addr=%0d data=%h scr=%0d row=%0d col=%0d rdy=%b required all 0",
               wr_en, wr_addr, wr_data, scroll_row, cursor_row, cursor_col, in_ready);
    end
    @(negedge clk100);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL ffr_ready: in_ready=%b wr_en=%b required 1 0", in_ready, wr_en);
    end
    @(posedge clk100); #1;
    checks++;
    if (wr_en !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ffr_abandoned: wr_en=%b in_ready=%b required 0 1", wr_en, in_ready);
    end
    send(8'h45);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 11'd0 || wr_data !== 8'h45) begin
      errors++;
      $display("FAIL ffr_E: en=%b addr=%0d data=%h required 1 0 45", wr_en, wr_addr, wr_data);
    end
  endtask

  initial begin
    test_reset();
    test_printable();
    test_line_wrap();
    test_scroll();
    test_scroll_wrap();
    test_last_cell();
    test_tab_bs();
    test_ff_full();
    test_ff_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/term_writer.md
Name: term_writer

Overview:
- Character-stream to text-buffer writer for the VGA text terminal.
- Consumes bytes from the UART/PS2 path over a valid/ready handshake and tracks the cursor.
- Interprets control characters CR, LF, BS, TAB and FF.
- Emits single-port write strobes into the text RAM. Scrolls by rotating a top-row offset instead of copying memory.
- Sits between the byte sources and the text-mode display. The display consumes scroll_row to rotate its read address.

Parameters:
- COLS, 80, characters per row.
- ROWS, 25, rows per screen.
- TAB_W, 8, tab stop spacing in columns; must be a power of two.
- FILL, 8'h20, character written when clearing cells.
- ADDR_W, $clog2(COLS*ROWS), text RAM address width.

Ports:
- clk100  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- in_data  in  8  incoming character byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  writer can accept a byte this cycle.
- wr_en  out  1  text RAM write strobe.
- wr_addr  out  ADDR_W  text RAM address, physical row*COLS + col.
- wr_data  out  8  text RAM write data.
- scroll_row  out  $clog2(ROWS)  physical row currently displayed at screen top.
- cursor_row  out  $clog2(ROWS)  logical cursor row, 0 = top of screen.
- cursor_col  out  $clog2(COLS)  cursor column.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, wr_en=0, wr_addr=0, wr_data=0.
  - scroll_row=0, cursor_row=0, cursor_col=0, in_ready=0.
  - Any clear in progress is abandoned.
- Handshake:
  - in_ready=1 only in IDLE with rst low.
  - A byte is accepted on a rising edge where in_valid && in_ready.
  - Bytes presented while in_ready=0 are neither consumed nor lost; the source holds them.
- Physical row: prow = scroll_row + cursor_row, minus ROWS if the sum is >= ROWS. The arithmetic is one bit wider than the row width, so there is no overflow.
- Outputs are registered. wr_en is high exactly the cycle after acceptance of a printable byte, and in every clear cycle. wr_en is 0 otherwise.
- Printable byte (0x20-0x7E):
  - Write in_data at prow*COLS + cursor_col.
  - If cursor_col == COLS-1: cursor_col=0 and perform a newline. Otherwise cursor_col+1.
- LF (0x0A): newline.
- Newline:
  - If cursor_row < ROWS-1: cursor_row+1, stay in IDLE.
  - Otherwise cursor_row stays ROWS-1. The old scroll_row value (the new bottom physical row) is latched as the clear target. scroll_row increments with wrap ROWS-1 -> 0. Go to CLEAR_LINE.
- CR (0x0D): cursor_col=0.
- BS (0x08): if cursor_col > 0, cursor_col-1. No erase. At column 0, no change.
- TAB (0x09): cursor_col = next multiple of TAB_W strictly greater than cursor_col, saturated at COLS-1. Never wraps.
- FF (0x0C): cursor 0,0, scroll_row=0, go to CLEAR_ALL.
- All other bytes (including 0x7F and >= 0x80) are consumed and ignored, with no write.
- CLEAR_LINE:
  - COLS consecutive cycles of wr_en=1, wr_data=FILL.
  - Addresses cover target*COLS through target*COLS+COLS-1, ascending.
  - Then IDLE.
- CLEAR_ALL:
  - ROWS*COLS consecutive cycles of wr_en=1, wr_data=FILL.
  - Addresses run 0 through ROWS*COLS-1.
  - Then IDLE.
- in_ready deasserts on the cycle after the accepting edge that enters a clear state. It reasserts on the cycle after the last clear write.
- A printable byte at the last cell (row ROWS-1, col COLS-1) first issues its own write, then enters CLEAR_LINE. Its write precedes the clear writes, with no gap.
- The cursor and scroll_row update on the accepting edge. They are stable throughout any clear.

Test Plan:
- After reset, send 'A' (0x41) -> one-cycle wr_en, wr_addr=0, wr_data=0x41, cursor_col=1. Then CR,LF -> cursor 1,0 with no writes.
- Send 80 'x' then 'B' -> 'B' written at wr_addr=80, cursor 1,1, no clear issued.
- Cursor at row 24, scroll_row=0, send LF -> scroll_row=1, in_ready low for 80 cycles, writes of 0x20 at addr 0..79. Then 'C' -> wr_addr=0.
- Scroll_row=24, cursor row 24, send LF -> scroll_row=0, clear addr 1920..1999 (old scroll_row 24 = new bottom row). Then 'D' -> wr_addr=1920.
- cursor_col=3, send TAB -> col 8. cursor_col=78, send TAB -> col 79. Col 0, send BS -> col 0. Col 5, send BS -> col 4. Send 0x07 -> no wr_en, in_ready stays high.
- Send FF -> 2000 FILL writes at addr 0..1999, cursor 0,0, scroll 0. Assert rst at write 500 -> all outputs at reset values immediately, and in_ready=1 on the first cycle after rst falls.
